// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART TX byte stream among three
// AXI4-Stream sources, prefixing each grant with that source's header byte.
module uart_tx_scheduler #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_BURST  = 16,
    parameter logic [DATA_WIDTH-1:0] HDR_S0     = 'd3,
    parameter logic [DATA_WIDTH-1:0] HDR_S1     = 'd2,
    parameter logic [DATA_WIDTH-1:0] HDR_S2     = 'd5
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic                  s0_tlast,

    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic                  s1_tlast,

    input  logic [DATA_WIDTH-1:0] s2_tdata,
    input  logic                  s2_tvalid,
    output logic                  s2_tready,
    input  logic                  s2_tlast,

    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,

    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic [7:0]            cut_count
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

    state_t     state_q, state_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] grant_q, grant_d;
    logic [7:0] count_q, count_d;
    logic [7:0] cut_q, cut_d;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    // Round-robin pick: first valid source starting at rr_ptr.
    logic [2:0] valid_vec;
    logic [1:0] cand0, cand1, cand2, pick_id;

    always_comb begin
        valid_vec = {s2_tvalid, s1_tvalid, s0_tvalid};
        cand0     = rr_ptr_q;
        cand1     = next_id(cand0);
        cand2     = next_id(cand1);
        if (valid_vec[cand0])      pick_id = cand0;
        else if (valid_vec[cand1]) pick_id = cand1;
        else                       pick_id = cand2;
    end

    logic [DATA_WIDTH-1:0] g_tdata, g_hdr;
    logic                  g_tvalid, g_tlast, burst_end;

    always_comb begin
        case (grant_q)
            2'd0:    begin g_tdata = s0_tdata; g_tvalid = s0_tvalid; g_tlast = s0_tlast; g_hdr = HDR_S0; end
            2'd1:    begin g_tdata = s1_tdata; g_tvalid = s1_tvalid; g_tlast = s1_tlast; g_hdr = HDR_S1; end
            default: begin g_tdata = s2_tdata; g_tvalid = s2_tvalid; g_tlast = s2_tlast; g_hdr = HDR_S2; end
        endcase
        burst_end = (count_q == 8'(MAX_BURST - 1));
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        count_d   = count_q;
        cut_d     = cut_q;
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tlast   = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        s2_tready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|valid_vec) begin
                    grant_d = pick_id;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                m_tvalid = 1'b1;
                m_tdata  = g_hdr;
                if (m_tready) begin
                    state_d = S_DATA;
                    count_d = 8'd0;
                end
            end
            S_DATA: begin
                m_tvalid  = g_tvalid;
                m_tdata   = g_tdata;
                m_tlast   = g_tlast | burst_end;
                s0_tready = (grant_q == 2'd0) & m_tready;
                s1_tready = (grant_q == 2'd1) & m_tready;
                s2_tready = (grant_q == 2'd2) & m_tready;
                if (g_tvalid && m_tready) begin
                    if (g_tlast || burst_end) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = next_id(grant_q);
                        // A forced cut leaves the rest of the packet for a later grant.
                        if (!g_tlast && cut_q != 8'hFF) cut_d = cut_q + 8'd1;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 2'd0;
            grant_q  <= 2'd0;
            count_q  <= 8'd0;
            cut_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            count_q  <= count_d;
            cut_q    <= cut_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign cut_count = cut_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-source packet queues drive the inputs and a
// transaction-level model predicts headers, pass-through, burst cuts and grant order.
module tb_uart_tx_scheduler;

    localparam int MAX_BURST = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] s_tdata [3];
    logic [2:0] s_tvalid;
    logic [2:0] s_tlast;
    wire  [2:0] s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic [1:0] grant_id;
    logic       busy;
    logic [7:0] cut_count;

    uart_tx_scheduler #(.MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_tdata  (s_tdata[0]),
        .s0_tvalid (s_tvalid[0]),
        .s0_tready (s_tready[0]),
        .s0_tlast  (s_tlast[0]),
        .s1_tdata  (s_tdata[1]),
        .s1_tvalid (s_tvalid[1]),
        .s1_tready (s_tready[1]),
        .s1_tlast  (s_tlast[1]),
        .s2_tdata  (s_tdata[2]),
        .s2_tvalid (s_tvalid[2]),
        .s2_tready (s_tready[2]),
        .s2_tlast  (s_tlast[2]),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .grant_id  (grant_id),
        .busy      (busy),
        .cut_count (cut_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pending beats per source: {tlast, data}.
    logic [8:0] src_q [3][$];
    logic [7:0] hdr_m [3] = '{8'd3, 8'd2, 8'd5};

    typedef enum {P_IDLE, P_HDR, P_DATA} mphase_t;
    mphase_t phase;
    int      rr_m, g_m, cnt_m, cut_m;

    function automatic int rr_pick(input logic [2:0] v, input int rr);
        for (int k = 0; k < 3; k++)
            if (v[(rr + k) % 3]) return (rr + k) % 3;
        return 0;
    endfunction

    task automatic model_reset();
        phase = P_IDLE;
        rr_m  = 0;
        g_m   = 0;
        cnt_m = 0;
        cut_m = 0;
    endtask

    task automatic add_pkt(input int src, input int len, input bit seq, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = seq ? base + 8'(i) : 8'($urandom_range(0, 255));
            src_q[src].push_back({(i == len - 1), d});
        end
    endtask

    task automatic drive(input bit rm);
        for (int i = 0; i < 3; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i] = rm ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_tdata[i]  = src_q[i][0][7:0];
                s_tlast[i]  = src_q[i][0][8];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = 8'h00;
                s_tlast[i]  = 1'b0;
            end
        end
        m_tready = rm ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    // One clock: check outputs at the falling edge, then update queues and inputs.
    task automatic step(input bit rm);
        logic [2:0] hs;
        logic [8:0] head;
        bit         end_of_burst;
        @(negedge clk);
        hs = s_tvalid & s_tready;
        if (rst_n) begin
            check("cut_count", cut_count, cut_m);
            case (phase)
                P_IDLE: begin
                    check("idle_m_tvalid", m_tvalid, 0);
                    check("idle_busy", busy, 0);
                    check("idle_s_tready", s_tready, 0);
                    if (|s_tvalid) begin
                        g_m   = rr_pick(s_tvalid, rr_m);
                        phase = P_HDR;
                    end
                end
                P_HDR: begin
                    check("hdr_m_tvalid", m_tvalid, 1);
                    check("hdr_m_tdata", m_tdata, hdr_m[g_m]);
                    check("hdr_m_tlast", m_tlast, 0);
                    check("hdr_grant_id", grant_id, g_m);
                    check("hdr_busy", busy, 1);
                    check("hdr_s_tready", s_tready, 0);
                    if (m_tready) begin
                        phase = P_DATA;
                        cnt_m = 0;
                    end
                end
                default: begin
                    check("data_busy", busy, 1);
                    check("data_grant_id", grant_id, g_m);
                    check("data_s_tready", s_tready, {2'b00, m_tready} << g_m);
                    check("data_m_tvalid", m_tvalid, s_tvalid[g_m]);
                    if (s_tvalid[g_m] && src_q[g_m].size() > 0) begin
                        head         = src_q[g_m][0];
                        end_of_burst = head[8] || (cnt_m == MAX_BURST - 1);
                        check("data_m_tdata", m_tdata, head[7:0]);
                        check("data_m_tlast", m_tlast, end_of_burst);
                        if (m_tready) begin
                            cnt_m++;
                            if (end_of_burst) begin
                                if (!head[8] && cut_m < 255) cut_m++;
                                rr_m  = (g_m + 1) % 3;
                                phase = P_IDLE;
                            end
                        end
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive(rm);
    endtask

    function automatic bit all_empty();
        return src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0;
    endfunction

    task automatic drain(input bit rm, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && phase == P_IDLE) && n < budget) begin
            step(rm);
            n++;
        end
        if (n >= budget) check("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s_tvalid = 3'b000;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_cut_count", cut_count, 0);
        check("rst_s_tready", s_tready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        s_tvalid = 3'b000;
        s_tlast  = 3'b000;
        for (int i = 0; i < 3; i++) s_tdata[i] = 8'h00;
        m_tready = 1'b0;
        model_reset();

        // Single s1 packet A1..A3.
        do_reset();
        add_pkt(1, 3, 1'b1, 8'hA1);
        drive(1'b0);
        drain(1'b0, 50);
        check("t1_cut_count", cut_count, 0);

        // Three simultaneous one-byte packets after reset: grants 0,1,2.
        do_reset();
        src_q[0].push_back({1'b1, 8'h10});
        src_q[1].push_back({1'b1, 8'h20});
        src_q[2].push_back({1'b1, 8'h30});
        drive(1'b0);
        drain(1'b0, 50);

        // 20-byte s2 packet split by the burst limit.
        add_pkt(2, 20, 1'b1, 8'h00);
        drive(1'b0);
        drain(1'b0, 100);
        check("t3_cut_count", cut_count, 1);

        // Random traffic with valid gaps and downstream backpressure.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 30) == 0 && src_q[i].size() < 80)
                    add_pkt(i, $urandom_range(1, 40), 1'b0, 8'h00);
            step(1'b1);
        end
        drain(1'b1, 20000);

        // Reset while the third byte of a 4-byte s0 packet is on the bus.
        add_pkt(0, 4, 1'b1, 8'hB0);
        drive(1'b0);
        n = 0;
        while (!(phase == P_DATA && cnt_m == 2) && n < 50) begin
            step(1'b0);
            n++;
        end
        if (n >= 50) check("midrst_reach_timeout", 1, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_m_tlast", m_tlast, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cut_count", cut_count, 0);
        for (int i = 0; i < 3; i++) src_q[i].delete();
        s_tvalid = 3'b000;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        src_q[0].push_back({1'b1, 8'h77});
        drive(1'b0);
        drain(1'b0, 50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin arbiter and framer that shares the single UART TX byte stream among three AXI4-Stream byte sources: rest-of-frame output, Ethernet PHY frames out, and app/brain status.
- Each grant emits one header byte carrying the source's packet-type code, then passes source bytes through until source tlast or a burst limit.
- Sits between the TCP/Ethernet/app producers and the UART transmitter, replacing per-byte header polling with packet-granular scheduling.

Parameters:
- DATA_WIDTH, 8, byte width of all streams.
- MAX_BURST, 16, maximum data bytes per grant (range 1..255).
- HDR_S0, 8'd3, header code for source 0 (REMAINING_LAYER).
- HDR_S1, 8'd2, header code for source 1 (ETH_FRAME_OUT).
- HDR_S2, 8'd5, header code for source 2 (BRAIN_STATUS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- s0_tdata/s0_tvalid/s0_tready/s0_tlast  in/in/out/in  DATA_WIDTH/1/1/1  rest-of-frame source.
- s1_tdata/s1_tvalid/s1_tready/s1_tlast  in/in/out/in  DATA_WIDTH/1/1/1  Ethernet PHY out source.
- s2_tdata/s2_tvalid/s2_tready/s2_tlast  in/in/out/in  DATA_WIDTH/1/1/1  app response source.
- m_tdata/m_tvalid/m_tready/m_tlast  out/out/in/out  DATA_WIDTH/1/1/1  UART TX stream.
- grant_id  out  2  current/last granted source (0..2).
- busy  out  1  high in S_HEADER or S_DATA.
- cut_count  out  8  saturating count of bursts ended by MAX_BURST rather than source tlast.

Behaviour:
- Reset: state S_IDLE, rr_ptr=0, grant_id=0, beat count=0, cut_count=0. m_tvalid=0, m_tlast=0, m_tdata=0, all s*_tready=0, busy=0.
- S_IDLE:
  - All s*_tready=0, m_tvalid=0.
  - If any s*_tvalid, pick the first valid source scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). Register grant_id and go to S_HEADER next cycle.
  - Valids are sampled only here; a source dropping tvalid before S_HEADER does not cancel the grant.
- S_HEADER:
  - m_tvalid=1, m_tdata=HDR_S<grant_id>, m_tlast=0, all s*_tready=0.
  - Hold until m_tready. On handshake: go to S_DATA, count=0.
- S_DATA (combinational pass-through of the granted source):
  - m_tdata=s<g>_tdata, m_tvalid=s<g>_tvalid, s<g>_tready=m_tready; non-granted readies are 0.
  - m_tlast = s<g>_tlast OR (count==MAX_BURST-1).
  - On handshake with s<g>_tlast=1: go to S_IDLE, rr_ptr=(grant_id+1) mod 3.
  - On handshake with count==MAX_BURST-1 and s<g>_tlast=0: forced end. Go to S_IDLE, rr_ptr=(grant_id+1) mod 3, cut_count++ (saturates at 255). The source's remaining bytes are delivered on a later grant behind a fresh header.
  - Other handshakes: count++.
  - Granted source deasserting tvalid mid-burst: wait indefinitely; no timeout, no grant change.
- Timing:
  - Minimum overhead per packet is 2 cycles: IDLE arbitration plus the header beat.
  - Back-to-back packets re-enter S_IDLE for 1 cycle between grants.
- Fairness:
  - With all three sources continuously valid, grant order is 0,1,2,0,...
  - No source waits more than 2 grants.
- Reset mid-operation (rst_n low in S_HEADER/S_DATA): grant abandoned at the next edge, no tlast emitted, all state returns to reset values.
- MAX_BURST=1: every grant carries one data byte with m_tlast=1. cut_count increments whenever that byte lacks source tlast.
- AXI rule: m_tdata/m_tlast are stable while m_tvalid=1 and m_tready=0 (header is constant; data is source-held).

Test Plan:
- Only s1 valid, 3-byte packet A1,A2,A3 (tlast on A3), m_tready=1: m output 02,A1,A2,A3; m_tlast only on A3; cut_count=0; rr_ptr=2 afterwards.
- s0,s1,s2 each holding a 1-byte packet (10,20,30 with tlast) simultaneously after reset: m output 03,10,02,20,05,30; grant_id sequence 0,1,2.
- s2 streaming 20 bytes 00..13 with tlast on 13, MAX_BURST=16: 05,00..0F with tlast on 0F; then 05,10..13 with tlast on 13; cut_count=1.
- Backpressure: m_tready toggling 1,0,0,1 during the header and data of s0 packet [55 (tlast)]: m_tdata holds 03 then 55 while stalled; s0_tready mirrors m_tready only in S_DATA.
- Granted s1 drops tvalid for 5 cycles mid-packet while s0 is valid: no s0 bytes emitted, s0_tready=0, and s1 resumes with no duplicated or lost bytes.
- rst_n asserted during the S_DATA byte 2 of a 4-byte s0 packet: next cycle m_tvalid=0, busy=0, cut_count=0; after release, a new s0 packet emits a fresh 03 header.
